idu_stage: RTL and testbench

// - Consumer end of the IFU valid/ready instruction handshake: accepts {inst, pc} from IFU, holds it in a 1-entry

---
 rtl/idu_stage_pkg.sv | 48 ++++
 rtl/idu_stage_if.sv | 38 +++
 rtl/idu_stage_imm_gen.sv | 30 +++
 rtl/idu_stage.sv | 111 +++++++++++
 tb/tb_idu_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/idu_stage_pkg.sv
// Shared decode definitions for the instruction decode stage:
// opcodes, instruction classes, immediate formats and the reset NOP.
package idu_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [3:0] {
        CLS_LUI    = 4'd0,
        CLS_AUIPC  = 4'd1,
        CLS_JAL    = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LOAD   = 4'd5,
        CLS_STORE  = 4'd6,
        CLS_OPIMM  = 4'd7,
        CLS_OP     = 4'd8,
        CLS_SYSTEM = 4'd9,
        CLS_ILL    = 4'd10
    } inst_class_e;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_R = 3'd5
    } imm_fmt_e;

    // RV32E only has x0..x15, so a referenced index with bit 4 set is out of range
    function automatic logic rve_index_bad(input logic [4:0] idx, input logic used);
        return used & idx[4];
    endfunction

endpackage

// File: rtl/idu_stage_if.sv
// Bundle of the IFU->IDU and IDU->EXU valid/ready handshakes plus decoded fields.
// The stage uses the slave view; the surrounding pipeline (or bench) uses master.
interface idu_stage_if #(
    parameter int XLEN = 32
);
    import idu_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    inst_class_e     out_class;
    logic [2:0]      out_funct3;
    logic            out_f7b5;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
               out_imm, out_class, out_funct3, out_f7b5, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_rs1, out_rs2, out_rd,
               out_imm, out_class, out_funct3, out_f7b5, out_illegal
    );

endinterface

// File: rtl/idu_stage_imm_gen.sv
// Immediate generator: reassembles and sign-extends the RV32 immediate for a
// given format. Only inst[31:7] carries immediate bits, so opcode is not an input.
module idu_stage_imm_gen
    import idu_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'h0;
        case (fmt)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'h000};
            FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'h0;
        endcase
    end

    // widening a signed value keeps the sign for XLEN > 32
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/idu_stage.sv
// Instruction decode stage: one-entry pipeline register between IFU and EXU,
// with purely combinational RV32I/E decode of the held instruction.
module idu_stage
    import idu_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit RVE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    idu_stage_if.slave  bus
);

    logic            valid_q, valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            in_fire;

    assign bus.in_ready = ~valid_q | bus.out_ready;
    assign in_fire      = bus.in_valid & bus.in_ready;

    // A capture always wins; otherwise the entry survives only until EXU accepts it
    always_comb begin
        valid_d = in_fire | (valid_q & ~bus.out_ready);
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (in_fire) begin
            inst_d = bus.in_inst;
            pc_d   = bus.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    logic [6:0]  opcode;
    logic [4:0]  rs1_raw, rs2_raw, rd_raw;
    logic        known, use_rs1, use_rs2, use_rd, illegal;
    inst_class_e cls;
    imm_fmt_e    fmt;

    assign opcode  = inst_q[6:0];
    assign rs1_raw = inst_q[19:15];
    assign rs2_raw = inst_q[24:20];
    assign rd_raw  = inst_q[11:7];

    always_comb begin
        known   = 1'b1;
        cls     = CLS_ILL;
        fmt     = FMT_R;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OPC_LUI:    begin cls = CLS_LUI;    fmt = FMT_U; use_rd = 1'b1; end
            OPC_AUIPC:  begin cls = CLS_AUIPC;  fmt = FMT_U; use_rd = 1'b1; end
            OPC_JAL:    begin cls = CLS_JAL;    fmt = FMT_J; use_rd = 1'b1; end
            OPC_JALR:   begin cls = CLS_JALR;   fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1; end
            OPC_LOAD:   begin cls = CLS_LOAD;   fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1; end
            OPC_OPIMM:  begin cls = CLS_OPIMM;  fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1; end
            OPC_SYSTEM: begin cls = CLS_SYSTEM; fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1; end
            OPC_STORE:  begin cls = CLS_STORE;  fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_BRANCH: begin cls = CLS_BRANCH; fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OP:     begin cls = CLS_OP;     fmt = FMT_R; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            default:    known = 1'b0;
        endcase

        illegal = (inst_q[1:0] != 2'b11) | ~known
                | (RVE & (rve_index_bad(rs1_raw, use_rs1)
                        | rve_index_bad(rs2_raw, use_rs2)
                        | rve_index_bad(rd_raw, use_rd)));

        // Illegal instructions still flow to EXU, but carry no operands or immediate
        if (illegal) begin
            cls     = CLS_ILL;
            fmt     = FMT_R;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
        end
    end

    idu_stage_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst (inst_q[31:7]),
        .fmt  (fmt),
        .imm  (bus.out_imm)
    );

    assign bus.out_valid   = valid_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_inst    = inst_q;
    assign bus.out_rs1     = use_rs1 ? rs1_raw : 5'd0;
    assign bus.out_rs2     = use_rs2 ? rs2_raw : 5'd0;
    assign bus.out_rd      = use_rd  ? rd_raw  : 5'd0;
    assign bus.out_class   = cls;
    assign bus.out_funct3  = inst_q[14:12];
    assign bus.out_f7b5    = inst_q[30];
    assign bus.out_illegal = illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: reset, single transfer, backpressure, streaming,
// decode of several formats, illegal encodings and reset while an entry is held.
module tb_idu_stage;
    import idu_stage_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    idu_stage_if #(.XLEN(32)) bus ();

    idu_stage #(
        .XLEN (32),
        .RVE  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic ready);
        bus.in_valid  = valid;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] inst_k;
        total = 0;
        bad   = 0;

        // Reset held for three cycles
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) step();
        checkOutput("reset_valid", bus.out_valid, 0);
        rst = 1'b0;
        step();
        checkOutput("post_reset_valid", bus.out_valid, 0);
        checkOutput("post_reset_in_ready", bus.in_ready, 1);
        checkOutput("post_reset_inst_nop", bus.out_inst, 32'h00000013);
        checkOutput("post_reset_pc", bus.out_pc, 0);

        // Single transfer: addi x1,x0,5
        applyStimulus(1'b1, 32'h00500093, 32'h80000000, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("single_valid", bus.out_valid, 1);
        checkOutput("single_class", bus.out_class, CLS_OPIMM);
        checkOutput("single_rd", bus.out_rd, 1);
        checkOutput("single_rs1", bus.out_rs1, 0);
        checkOutput("single_rs2", bus.out_rs2, 0);
        checkOutput("single_imm", bus.out_imm, 5);
        checkOutput("single_pc", bus.out_pc, 32'h80000000);
        checkOutput("single_illegal", bus.out_illegal, 0);
        step();
        checkOutput("single_drained", bus.out_valid, 0);
        checkOutput("idle_keeps_inst", bus.out_inst, 32'h00500093);

        // Backpressure: addi x2,x0,10 held while a branch waits upstream
        applyStimulus(1'b1, 32'h00A00113, 32'h00000100, 1'b0);
        step();
        applyStimulus(1'b1, 32'hFE010EE3, 32'h00000104, 1'b0);
        #1;
        checkOutput("bp_in_ready_low", bus.in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp_hold_valid", bus.out_valid, 1);
            checkOutput("bp_hold_inst", bus.out_inst, 32'h00A00113);
            checkOutput("bp_hold_pc", bus.out_pc, 32'h00000100);
            checkOutput("bp_hold_imm", bus.out_imm, 10);
            checkOutput("bp_hold_rd", bus.out_rd, 2);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_high", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("bp_second_valid", bus.out_valid, 1);
        checkOutput("bp_second_inst", bus.out_inst, 32'hFE010EE3);
        checkOutput("bp_second_pc", bus.out_pc, 32'h00000104);
        checkOutput("bp_second_class", bus.out_class, CLS_BRANCH);
        checkOutput("bp_second_imm", bus.out_imm, 32'hFFFFFFFC);
        checkOutput("bp_second_rs1", bus.out_rs1, 2);
        checkOutput("bp_second_rs2", bus.out_rs2, 0);
        checkOutput("bp_second_rd", bus.out_rd, 0);
        step();
        checkOutput("bp_drained", bus.out_valid, 0);

        // Streaming: addi x1,x0,k for k=1..8, one per cycle
        for (int k = 1; k <= 8; k++) begin
            inst_k = (32'(k) << 20) | 32'h00000093;
            applyStimulus(1'b1, inst_k, 32'h00000200 + 32'(4 * k), 1'b1);
            step();
            checkOutput("stream_valid", bus.out_valid, 1);
            checkOutput("stream_inst", bus.out_inst, inst_k);
            checkOutput("stream_imm", bus.out_imm, k);
            checkOutput("stream_pc", bus.out_pc, 32'h00000200 + 32'(4 * k));
            checkOutput("stream_in_ready", bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        step();
        checkOutput("stream_drained", bus.out_valid, 0);

        // Store: sw x2,-8(x1)
        applyStimulus(1'b1, 32'hFE20AC23, 32'h00000300, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("store_class", bus.out_class, CLS_STORE);
        checkOutput("store_imm", bus.out_imm, 32'hFFFFFFF8);
        checkOutput("store_rs1", bus.out_rs1, 1);
        checkOutput("store_rs2", bus.out_rs2, 2);
        checkOutput("store_rd", bus.out_rd, 0);
        checkOutput("store_funct3", bus.out_funct3, 2);

        // LUI x5,0x12345
        applyStimulus(1'b1, 32'h123452B7, 32'h00000304, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("lui_class", bus.out_class, CLS_LUI);
        checkOutput("lui_imm", bus.out_imm, 32'h12345000);
        checkOutput("lui_rd", bus.out_rd, 5);
        checkOutput("lui_rs1", bus.out_rs1, 0);

        // All-ones word: unlisted opcode
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h00000308, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("ill_ones_valid", bus.out_valid, 1);
        checkOutput("ill_ones_flag", bus.out_illegal, 1);
        checkOutput("ill_ones_class", bus.out_class, CLS_ILL);
        checkOutput("ill_ones_rs1", bus.out_rs1, 0);
        checkOutput("ill_ones_rs2", bus.out_rs2, 0);
        checkOutput("ill_ones_rd", bus.out_rd, 0);

        // RV32E: rd=x17 is out of range
        applyStimulus(1'b1, 32'h01000893, 32'h0000030C, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("ill_rve_flag", bus.out_illegal, 1);
        checkOutput("ill_rve_class", bus.out_class, CLS_ILL);
        checkOutput("ill_rve_rd", bus.out_rd, 0);

        // RV32E boundary: rd=x15 is still legal
        applyStimulus(1'b1, 32'h00000793, 32'h00000310, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("rve_x15_flag", bus.out_illegal, 0);
        checkOutput("rve_x15_rd", bus.out_rd, 15);

        // Compressed-style low bits are not supported
        applyStimulus(1'b1, 32'h00000001, 32'h00000314, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checkOutput("ill_lowbits_flag", bus.out_illegal, 1);
        checkOutput("ill_lowbits_class", bus.out_class, CLS_ILL);

        // Reset while an entry is stalled: it must never reach EXU
        applyStimulus(1'b1, 32'h00700093, 32'h00000400, 1'b0);
        step();
        checkOutput("midrst_held", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_valid", bus.out_valid, 0);
        checkOutput("midrst_inst_nop", bus.out_inst, 32'h00000013);
        checkOutput("midrst_pc", bus.out_pc, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("midrst_no_emit", bus.out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
